// File: rtl/vga_window_scanout_if.sv
// Frame-buffer read port: the scanout drives a word address, memory returns the pixel word
// a fixed number of clocks later.
interface vga_window_scanout_if;
  logic [31:0] memAddress;
  logic [31:0] pixel;

  modport master (output memAddress, input pixel);
  modport slave (input memAddress, output pixel);
endinterface

// File: rtl/vga_window_scanout.sv
// VGA timing generator that scans a SCALE-replicated window out of a frame buffer.
// Define VGA_SCANOUT_DBUF_EN to enable double buffering between BASE0 and BASE1 via swap_req.
module vga_window_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WIN_W    = 200,
  parameter int WIN_H    = 200,
  parameter int SCALE    = 1,
  parameter int MEM_LAT  = 1,
  parameter logic [31:0] BASE0 = 32'd0,
  parameter logic [31:0] BASE1 = 32'd40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  win_x0,
  input  logic [9:0]  win_y0,
  input  logic [23:0] bg_color,
  input  logic        swap_req,
  vga_window_scanout_if.master mem,
  output logic        hsync,
  output logic        vsync,
  output logic        sync_b,
  output logic        blank_b,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int WIN_PW   = WIN_W * SCALE;
  localparam int WIN_PH   = WIN_H * SCALE;
  localparam int PIPE     = MEM_LAT + 1;
  localparam logic [1:0] SUB_LAST = 2'(SCALE - 1);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       win;
    logic       first;
    logic [9:0] px;
    logic [9:0] py;
  } ctl_t;

  localparam ctl_t IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, win: 1'b0, first: 1'b0,
                            px: 10'd0, py: 10'd0};

  logic [9:0] hc, vc, wx, wy, ox, oy;
  logic line_end, frame_end, at_origin;
  logic signed [11:0] dx, dy;
  logic h_in, v_in, in_win;
  logic sel_now;
  logic [31:0] base, col, row_base;
  logic [1:0] sub_x, sub_y;
  ctl_t cur, last;
  ctl_t pipe [0:PIPE-1];
  logic unused_bits;

  assign line_end  = (hc == 10'(H_TOTAL - 1));
  assign frame_end = line_end && (vc == 10'(V_TOTAL - 1));
  assign at_origin = (hc == 10'd0) && (vc == 10'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else if (line_end) begin
      hc <= 10'd0;
      vc <= frame_end ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // The origin is sampled at (0,0); that pixel already uses the new value so a frame is never split.
  assign ox = at_origin ? win_x0 : wx;
  assign oy = at_origin ? win_y0 : wy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wx <= 10'd0;
      wy <= 10'd0;
    end else if (at_origin) begin
      wx <= win_x0;
      wy <= win_y0;
    end
  end

  assign dx     = $signed({2'b00, hc}) - $signed({2'b00, ox});
  assign dy     = $signed({2'b00, vc}) - $signed({2'b00, oy});
  assign h_in   = !dx[11] && (int'(dx) < WIN_PW);
  assign v_in   = !dy[11] && (int'(dy) < WIN_PH);
  assign in_win = h_in && v_in;

`ifdef VGA_SCANOUT_DBUF_EN
  logic base_sel, pending;

  // A request landing on the (0,0) edge becomes the new pending flag, so it applies one frame later.
  assign sel_now = at_origin ? (base_sel ^ pending) : base_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_sel <= 1'b0;
      pending  <= 1'b0;
    end else if (at_origin) begin
      base_sel <= base_sel ^ pending;
      pending  <= swap_req;
    end else if (swap_req) begin
      pending  <= 1'b1;
    end
  end
`else
  assign sel_now = 1'b0;
`endif

  assign base = sel_now ? BASE1 : BASE0;

  // Sub-pixel counters replace a divide by SCALE; they keep running through clipped pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem.memAddress <= BASE0;
      col            <= 32'd0;
      sub_x          <= 2'd0;
      row_base       <= 32'd0;
      sub_y          <= 2'd0;
    end else begin
      if (in_win)
        mem.memAddress <= base + row_base + col;
      if (line_end || !in_win) begin
        col   <= 32'd0;
        sub_x <= 2'd0;
      end else if (sub_x == SUB_LAST) begin
        col   <= col + 32'd1;
        sub_x <= 2'd0;
      end else begin
        sub_x <= sub_x + 2'd1;
      end
      if (line_end) begin
        if (frame_end || !v_in) begin
          row_base <= 32'd0;
          sub_y    <= 2'd0;
        end else if (sub_y == SUB_LAST) begin
          row_base <= row_base + 32'(WIN_W);
          sub_y    <= 2'd0;
        end else begin
          sub_y    <= sub_y + 2'd1;
        end
      end
    end
  end

  always_comb begin
    cur       = IDLE;
    cur.hs    = !((hc >= 10'(HS_START)) && (hc < 10'(HS_END)));
    cur.vs    = !((vc >= 10'(VS_START)) && (vc < 10'(VS_END)));
    cur.act   = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));
    cur.win   = in_win;
    cur.first = at_origin;
    cur.px    = hc;
    cur.py    = vc;
  end

  // Control travels alongside the memory read so it meets the returning pixel word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE; i++)
        pipe[i] <= IDLE;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < PIPE; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[PIPE-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_b     <= 1'b0;
      {r, g, b}   <= 24'd0;
      x           <= 10'd0;
      y           <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= last.hs;
      vsync       <= last.vs;
      blank_b     <= last.act;
      x           <= last.px;
      y           <= last.py;
      frame_start <= last.first;
      if (!last.act)
        {r, g, b} <= 24'd0;
      else if (!last.win)
        {r, g, b} <= bg_color;
      else
        {r, g, b} <= mem.pixel[23:0];
    end
  end

  assign sync_b      = 1'b0;
  assign unused_bits = &{1'b0, mem.pixel[31:24], swap_req};

endmodule

// File: tb/tb_vga_window_scanout.sv
// Directed bench for vga_window_scanout: two small-timing instances (SCALE=1/MEM_LAT=1 and
// SCALE=2/MEM_LAT=3) with echo memories; frames are captured per (x,y) and checked from a table.
module tb_vga_window_scanout;

  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 30, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG_A = 24'h123456;
  localparam logic [23:0] BG_B = 24'h654321;
`ifdef VGA_SCANOUT_DBUF_EN
  localparam int ALT = 1000;
`else
  localparam int ALT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, swap_a, swap_b;
  logic [9:0] win_x0_a, win_y0_a, win_x0_b, win_y0_b;
  logic hs_a, vs_a, sb_a, blank_a, fs_a, hs_b, vs_b, sb_b, blank_b, fs_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [31:0] pix_a, pb1, pb2, pb3;

  vga_window_scanout_if mem_a ();
  vga_window_scanout_if mem_b ();

  vga_window_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .WIN_W(8), .WIN_H(6), .SCALE(1), .MEM_LAT(1),
    .BASE0(32'd0), .BASE1(32'd1000)
  ) dut_a (
    .clk(clk), .rst(rst_a), .win_x0(win_x0_a), .win_y0(win_y0_a), .bg_color(BG_A),
    .swap_req(swap_a), .mem(mem_a), .hsync(hs_a), .vsync(vs_a), .sync_b(sb_a),
    .blank_b(blank_a), .r(r_a), .g(g_a), .b(b_a), .x(x_a), .y(y_a), .frame_start(fs_a)
  );

  vga_window_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .WIN_W(8), .WIN_H(6), .SCALE(2), .MEM_LAT(3),
    .BASE0(32'd0), .BASE1(32'd1000)
  ) dut_b (
    .clk(clk), .rst(rst_b), .win_x0(win_x0_b), .win_y0(win_y0_b), .bg_color(BG_B),
    .swap_req(swap_b), .mem(mem_b), .hsync(hs_b), .vsync(vs_b), .sync_b(sb_b),
    .blank_b(blank_b), .r(r_b), .g(g_b), .b(b_b), .x(x_b), .y(y_b), .frame_start(fs_b)
  );

  // Echo memories: the pixel word is the address, top byte marked so masking is visible.
  always @(posedge clk) begin
    pix_a <= {8'hAA, mem_a.memAddress[23:0]};
    pb1   <= {8'hAA, mem_b.memAddress[23:0]};
    pb2   <= pb1;
    pb3   <= pb2;
  end
  assign mem_a.pixel = pix_a;
  assign mem_b.pixel = pb3;

  int cyc;
  always @(posedge clk) begin
    if (!rst_a) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [26:0] cap_a [0:3][0:VT-1][0:HT-1];
  logic [26:0] cap_b [0:1][0:VT-1][0:HT-1];
  int frame_a = -1, frame_b = -1;
  bit skip_a = 1'b1, skip_b = 1'b1;
  int fs1_a = -1, fs2_a = -1, fs1_b = -1, hs_low_at = -1, hs_high_at = -1;

  initial begin
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < VT; j++)
        for (int i = 0; i < HT; i++) begin
          cap_a[f][j][i] = '1;
          if (f < 2) cap_b[f][j][i] = '1;
        end
    forever begin
      @(negedge clk);
      if (!rst_a) skip_a = 1'b1;
      else begin
        if (fs_a) begin
          frame_a++;
          skip_a = 1'b0;
          if (fs1_a < 0) fs1_a = cyc;
          else if (fs2_a < 0) fs2_a = cyc;
        end
        if (!hs_a && hs_low_at < 0) hs_low_at = cyc;
        if (hs_low_at >= 0 && hs_high_at < 0 && hs_a) hs_high_at = cyc;
        if (!skip_a && frame_a >= 0 && frame_a < 4 && x_a < HT && y_a < VT)
          cap_a[frame_a][y_a][x_a] = {blank_a, hs_a, vs_a, r_a, g_a, b_a};
      end
      if (!rst_b) skip_b = 1'b1;
      else begin
        if (fs_b) begin
          frame_b++;
          skip_b = 1'b0;
          if (fs1_b < 0) fs1_b = cyc;
        end
        if (!skip_b && frame_b >= 0 && frame_b < 2 && x_b < HT && y_b < VT)
          cap_b[frame_b][y_b][x_b] = {blank_b, hs_b, vs_b, r_b, g_b, b_b};
      end
    end
  end

  typedef struct {
    int dut;
    int frame;
    int px;
    int py;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total = 0;

  function automatic logic [26:0] act(input int c);
    return {3'b111, 24'(c)};
  endfunction

  function automatic logic [26:0] blk(input logic h, input logic v);
    return {1'b0, h, v, 24'h0};
  endfunction

  task automatic addVec(input int d, input int f, input int px, input int py, input logic [26:0] e);
    vec_t v;
    v.dut = d; v.frame = f; v.px = px; v.py = py; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic applyStimulus(input int at_cyc, input logic [9:0] nx, input logic [9:0] ny,
                               input logic swap);
    while (cyc < at_cyc) @(negedge clk);
    win_x0_a = nx;
    win_y0_a = ny;
    swap_a   = swap;
    @(negedge clk);
    swap_a   = 1'b0;
  endtask

  initial begin
    int k;
    logic [26:0] got;

    // Frame 0 of A: window at (0,0), plus sync/blank geometry.
    addVec(0, 0, 0, 0, act(0));      addVec(0, 0, 7, 0, act(7));
    addVec(0, 0, 0, 1, act(8));      addVec(0, 0, 8, 0, act(BG_A));
    addVec(0, 0, 7, 5, act(47));     addVec(0, 0, 0, 6, act(BG_A));
    addVec(0, 0, 5, 4, act(37));     addVec(0, 0, 39, 29, act(BG_A));
    addVec(0, 0, 40, 0, blk(1, 1));  addVec(0, 0, 43, 0, blk(1, 1));
    addVec(0, 0, 44, 0, blk(0, 1));  addVec(0, 0, 49, 0, blk(0, 1));
    addVec(0, 0, 50, 0, blk(1, 1));  addVec(0, 0, 0, 31, blk(1, 1));
    addVec(0, 0, 0, 32, blk(1, 0));  addVec(0, 0, 0, 33, blk(1, 0));
    addVec(0, 0, 0, 34, blk(1, 1));  addVec(0, 0, 44, 33, blk(0, 0));
    // Frame 1 of A: window moved to (20,0); buffer swapped in the DBUF build.
    addVec(0, 1, 20, 0, act(ALT));      addVec(0, 1, 19, 0, act(BG_A));
    addVec(0, 1, 0, 0, act(BG_A));      addVec(0, 1, 27, 2, act(ALT + 23));
    addVec(0, 1, 28, 2, act(BG_A));     addVec(0, 1, 20, 5, act(ALT + 40));
    addVec(0, 1, 20, 6, act(BG_A));
    // Frame 2 of A: window at (36,27), clipped right and bottom.
    addVec(0, 2, 36, 27, act(0));       addVec(0, 2, 39, 27, act(3));
    addVec(0, 2, 36, 28, act(8));       addVec(0, 2, 39, 29, act(19));
    addVec(0, 2, 35, 27, act(BG_A));    addVec(0, 2, 40, 27, blk(1, 1));
    addVec(0, 2, 36, 26, act(BG_A));    addVec(0, 2, 0, 0, act(BG_A));
    // Frame 3 of A: swap requested on the frame edge lands here.
    addVec(0, 3, 37, 28, act(ALT + 9));
    // B: SCALE=2 window at (10,5), MEM_LAT=3.
    addVec(1, 0, 10, 5, act(0));   addVec(1, 0, 11, 5, act(0));
    addVec(1, 0, 10, 6, act(0));   addVec(1, 0, 11, 6, act(0));
    addVec(1, 0, 12, 5, act(1));   addVec(1, 0, 13, 6, act(1));
    addVec(1, 0, 10, 7, act(8));   addVec(1, 0, 25, 16, act(47));
    addVec(1, 0, 26, 5, act(BG_B)); addVec(1, 0, 9, 5, act(BG_B));
    addVec(1, 0, 10, 4, act(BG_B)); addVec(1, 0, 10, 17, act(BG_B));
    addVec(1, 1, 12, 6, act(1));   addVec(1, 1, 10, 7, act(8));

    rst_a = 1'b0; rst_b = 1'b0; swap_a = 1'b0; swap_b = 1'b0;
    win_x0_a = 10'd0;  win_y0_a = 10'd0;
    win_x0_b = 10'd10; win_y0_b = 10'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset hsync", 32'(hs_a), 32'd1);
    checkOutput("reset vsync", 32'(vs_a), 32'd1);
    checkOutput("reset blank_b", 32'(blank_a), 32'd0);
    checkOutput("reset rgb", 32'({r_a, g_a, b_a}), 32'd0);
    checkOutput("reset x", 32'(x_a), 32'd0);
    checkOutput("reset y", 32'(y_a), 32'd0);
    checkOutput("reset frame_start", 32'(fs_a), 32'd0);
    checkOutput("reset memAddress", mem_a.memAddress, 32'd0);
    checkOutput("sync_b", 32'(sb_a), 32'd0);
    checkOutput("reset B hsync", 32'(hs_b), 32'd1);
    rst_a = 1'b1; rst_b = 1'b1;

    applyStimulus(1 + 3 * HT + 10, 10'd20, 10'd0, 1'b0);
    applyStimulus(1 + 10 * HT + 5, 10'd20, 10'd0, 1'b1);

    // B: reset mid-line, held for three clocks.
    while (cyc < 1 + 20 * HT + 30) @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("B midreset hsync", 32'(hs_b), 32'd1);
    checkOutput("B midreset vsync", 32'(vs_b), 32'd1);
    checkOutput("B midreset blank_b", 32'(blank_b), 32'd0);
    checkOutput("B midreset rgb", 32'({r_b, g_b, b_b}), 32'd0);
    checkOutput("B midreset xy", 32'({x_b, y_b}), 32'd0);
    checkOutput("B midreset memAddress", mem_b.memAddress, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!fs_b && k < 20);
    checkOutput("B frame_start after release", k, 5);
    checkOutput("B xy at frame_start", 32'({x_b, y_b}), 32'd0);

    applyStimulus(1 + FRAME + 20 * HT + 10, 10'd36, 10'd27, 1'b0);
    applyStimulus(1 + FRAME + 25 * HT + 5, 10'd36, 10'd27, 1'b1);
    applyStimulus(2 * FRAME, 10'd36, 10'd27, 1'b1);

    while (cyc < 4 * FRAME + 100) @(negedge clk);

    checkOutput("A first frame_start", fs1_a, 3);
    checkOutput("A frame period", fs2_a - fs1_a, FRAME);
    checkOutput("A first hsync low", hs_low_at, HA + HF + 3);
    checkOutput("A hsync width", hs_high_at - hs_low_at, HS);
    checkOutput("B first frame_start", fs1_b, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut == 0) got = cap_a[vecs[i].frame][vecs[i].py][vecs[i].px];
      else                  got = cap_b[vecs[i].frame][vecs[i].py][vecs[i].px];
      checkOutput($sformatf("dut%0d f%0d (%0d,%0d)", vecs[i].dut, vecs[i].frame,
                            vecs[i].px, vecs[i].py), 32'(got), 32'(vecs[i].exp));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_window_scanout.md
VGA_WINDOW_SCANOUT -- requirements
Module: vga_window_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters WIN_W/WIN_H, default 200/200, window size in source pixels.
REQ-006 SHALL have parameter SCALE, default 1 (legal 1..4), each source pixel is replicated SCALEx SCALE on screen.
REQ-007 SHALL have parameter MEM_LAT, default 1 (legal 0..3), clocks from memAddress to valid pixel.
REQ-008 SHALL have parameters BASE0/BASE1, default 0/40000, word base addresses of frame buffers.
REQ-009 clk  in  1  pixel clock (vgaclk domain); only clock.
REQ-010 rst  in  1  synchronous reset, active-low.
REQ-011 win_x0, win_y0  in  10 each  window origin in screen pixels.
REQ-012 bg_color  in  24  {r,g,b} shown outside window in active area.
REQ-013 pixel  in  32  frame-buffer word; r=[23:16], g=[15:8], b=[7:0].
REQ-014 swap_req  in  1  request to change displayed buffer (DBUF build only).
REQ-015 memAddress  out  32  frame-buffer word address.
REQ-016 hsync, vsync  out  1 each  active-low syncs.
REQ-017 sync_b, blank_b  out  1 each  sync_b constant 0; blank_b high in active area.
REQ-018 r, g, b  out  8 each  colour.
REQ-019 x, y  out  10 each  screen coordinate aligned with r/g/b.
REQ-020 frame_start  out  1  one-clock pulse when the pixel at (0,0) reaches the outputs.

Function
REQ-021 Horizontal counter hc SHALL count 0..H_TOTAL-1 (H_TOTAL=sum of H params), wrap to 0 and advance vc; vc SHALL wrap at V_TOTAL-1.
REQ-022 hsync SHALL be 0 for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vc.
REQ-023 blank_b SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE.
REQ-024 in_win SHALL be 1 iff hc-wx in [0,WIN_W*SCALE) and vc-wy in [0,WIN_H*SCALE), using shadowed origin wx,wy.
REQ-025 wx,wy SHALL load from win_x0,win_y0 only at hc=0,vc=0; mid-frame changes SHALL take effect next frame.
REQ-026 memAddress SHALL equal base+row*WIN_W+col, row=(vc-wy)/SCALE, col=(hc-wx)/SCALE, computed with sub-pixel counters (no divider); held when not in_win.
REQ-027 All outputs SHALL be delayed by L=MEM_LAT+2 clocks after counter state, so hsync, vsync, blank_b, x, y, r/g/b stay mutually aligned.
REQ-028 Colour SHALL be 0 when blank_b=0; bg_color when active and not in_win; pixel[23:0] otherwise.
REQ-029 Window partly off-screen (wx+WIN_W*SCALE>H_ACTIVE) SHALL clip; addresses SHALL still advance per source pixel so visible content is unshifted.
REQ-030 Line wrap: col SHALL restart at 0 each line; row SHALL advance only after SCALE window lines.

Reset
REQ-031 While rst=0 at clk edge: hc=vc=0, pipeline cleared, hsync=vsync=1, blank_b=0, r=g=b=0, x=y=0, memAddress=BASE0, frame_start=0, wx=wy=0, buffer select=0.
REQ-032 Reset asserted mid-line SHALL restart timing from (0,0) on the first clock after release; first frame_start exactly L clocks after release.

Configuration
REQ-033 With VGA_SCANOUT_DBUF_EN defined: a swap_req pulse SHALL set a pending flag; at hc=0,vc=0 a pending flag SHALL toggle base between BASE0/BASE1 and clear; simultaneous swap_req at that edge SHALL apply at the next frame.
REQ-034 Without VGA_SCANOUT_DBUF_EN: swap_req ignored, base fixed at BASE0.

Verification
REQ-035 Reset release, defaults -> first hsync low at clk 656+L, 96 clocks wide; vsync low on lines 490-491; frame period 800x525 clocks.
REQ-036 win (0,0), SCALE=1, pixel=memAddress echo -> at (0,0) rgb=0x000000 from addr 0; at (199,0) addr 199; at (0,1) addr 200; at (200,0) bg_color.
REQ-037 SCALE=2, win (100,50) -> screen (100..101,50..51) all addr 0; (102,50) addr 1; (100,52) addr 200.
REQ-038 win_x0 changed 0->300 at line 100 -> window moves only in next frame; current frame unchanged.
REQ-039 DBUF_EN, swap_req at line 10 -> next frame addresses start at 40000; second swap -> back to 0; swap_req at frame edge -> deferred one frame.
REQ-040 rst low for 3 clocks at hc=400,vc=200 -> outputs at reset values; frame_start L clocks after release; MEM_LAT=3 build keeps rgb aligned with x.
